// File: rtl/max_seq_ctrl.sv
// max_seq_ctrl: folds a batch of N unsigned bytes through one shared MAX unit and emits the batch peak.
// Define MAX_SEQ_ARGMAX_EN to also report the position of the peak on out_idx_o.
module max_unit (
  input  logic [7:0] x_i,
  input  logic [7:0] y_i,
  output logic [7:0] max_o,
  output logic       gt_o
);
  assign gt_o  = {1'b0, y_i} > {1'b0, x_i};
  assign max_o = gt_o ? y_i : x_i;
endmodule

module max_seq_ctrl #(
  parameter int N  = 4,
  parameter int IW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [7:0]    in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic [7:0]    out_max_o,
  output logic          out_valid_o,
  input  logic          out_ready_i
`ifdef MAX_SEQ_ARGMAX_EN
  ,
  output logic [IW-1:0] out_idx_o
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;
  localparam logic [7:0] LAST = 8'(N - 1);
  state_t     state_q, state_d;
  logic [7:0] max_q, max_d, cnt_q, cnt_d, mx;
  logic       gt, acc;
  max_unit u_max (.x_i(max_q), .y_i(in_data_i), .max_o(mx), .gt_o(gt));
  assign acc         = in_valid_i && state_q != S_DONE;
  assign in_ready_o  = state_q != S_DONE;
  assign out_valid_o = state_q == S_DONE;
  assign out_max_o   = max_q;
  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (acc) begin
        max_d   = in_data_i;
        cnt_d   = 8'd1;
        state_d = (N == 1) ? S_DONE : S_ACC;
      end
      S_ACC: if (acc) begin
        max_d   = mx;
        cnt_d   = cnt_q + 8'd1;
        state_d = (cnt_q == LAST) ? S_DONE : S_ACC;
      end
      default: if (out_ready_i) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      max_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef MAX_SEQ_ARGMAX_EN
  logic [IW-1:0] idx_q, idx_d;
  assign out_idx_o = idx_q;
  // only a strictly larger sample moves the index, so ties keep the earlier one
  always_comb begin
    idx_d = idx_q;
    if (acc) idx_d = (state_q == S_IDLE) ? '0 : gt ? IW'(cnt_q) : idx_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) idx_q <= '0;
    else idx_q <= idx_d;
  end
`endif
endmodule

// File: tb/tb_max_seq_ctrl.sv
// tb_max_seq_ctrl: directed bench for max_seq_ctrl, N=4 and N=1 instances fed the same stream.
module tb_max_seq_ctrl;
  logic       clk = 0, rst = 1;
  logic [7:0] in_data = 0;
  logic       in_valid = 0, out_ready = 1;
  logic       rdy [2];
  logic       vld [2];
  logic [7:0] mxo [2];
  logic [7:0] idxo [2];
  int         errs = 0, chks = 0;
  logic [7:0] smp [2][256];
  int         cnt_m [2];
  bit         done_m [2];

  always #5 clk = ~clk;

  max_seq_ctrl #(.N(4), .IW(8)) dut0 (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(rdy[0]), .out_max_o(mxo[0]), .out_valid_o(vld[0]), .out_ready_i(out_ready)
`ifdef MAX_SEQ_ARGMAX_EN
    , .out_idx_o(idxo[0])
`endif
  );
  max_seq_ctrl #(.N(1), .IW(8)) dut1 (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(rdy[1]), .out_max_o(mxo[1]), .out_valid_o(vld[1]), .out_ready_i(out_ready)
`ifdef MAX_SEQ_ARGMAX_EN
    , .out_idx_o(idxo[1])
`endif
  );
`ifndef MAX_SEQ_ARGMAX_EN
  assign idxo[0] = 0;
  assign idxo[1] = 0;
`endif

  task automatic chk(input string nm, input int act, input int exp);
    chks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int nn(input int k);
    return k == 0 ? 4 : 1;
  endfunction

  // batch peak and first position of it, straight from the recorded samples
  function automatic void ref_max(input int k, output int m, output int ix);
    m = smp[k][0];
    ix = 0;
    for (int i = 1; i < nn(k); i++)
      if (smp[k][i] > m) begin
        m = smp[k][i];
        ix = i;
      end
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        done_m[k] = 0;
        cnt_m[k] = 0;
      end else if (done_m[k]) begin
        if (out_ready) begin
          done_m[k] = 0;
          cnt_m[k] = 0;
        end
      end else if (in_valid) begin
        smp[k][cnt_m[k]] = in_data;
        cnt_m[k]++;
        if (cnt_m[k] == nn(k)) done_m[k] = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst)
      for (int k = 0; k < 2; k++) begin
        int m, ix;
        chk($sformatf("in_ready[N=%0d]", nn(k)), int'(rdy[k]), int'(!done_m[k]));
        chk($sformatf("out_valid[N=%0d]", nn(k)), int'(vld[k]), int'(done_m[k]));
        if (done_m[k]) begin
          ref_max(k, m, ix);
          chk($sformatf("out_max[N=%0d]", nn(k)), int'(mxo[k]), m);
`ifdef MAX_SEQ_ARGMAX_EN
          chk($sformatf("out_idx[N=%0d]", nn(k)), int'(idxo[k]), ix);
`endif
        end
      end
  end

  task automatic send(input logic [7:0] v);
    in_valid = 1;
    in_data = v;
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    in_data = 8'hFF;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("reset out_valid", int'(vld[0]), 0);
    chk("reset in_ready", int'(rdy[0]), 1);
    chk("reset out_max", int'(mxo[0]), 0);
    @(posedge clk);
    #1 rst = 0;
    idle(1);
    send(15); send(5); send(27); send(10);
    chk("t1 out_valid", int'(vld[0]), 1);
    chk("t1 out_max", int'(mxo[0]), 27);
    chk("t1 in_ready busy", int'(rdy[0]), 0);
    idle(1);
    chk("t1 in_ready after", int'(rdy[0]), 1);
    chk("t1 out_valid after", int'(vld[0]), 0);
    send(8'h7F); send(8'h80); send(8'h01); send(8'h00);
    chk("t2 unsigned max", int'(mxo[0]), 128);
    idle(1);
    out_ready = 0;
    send(3); send(9); send(6); send(1);
    in_valid = 1;
    in_data = 8'hFF;
    repeat (5) @(posedge clk);
    #1;
    chk("t3 held valid", int'(vld[0]), 1);
    chk("t3 held max", int'(mxo[0]), 9);
    chk("t3 held ready", int'(rdy[0]), 0);
    in_valid = 0;
    out_ready = 1;
    idle(1);
    chk("t3 released", int'(vld[0]), 0);
    send(12); idle(3); send(40); idle(1); send(7); send(33);
    chk("t4 gaps max", int'(mxo[0]), 40);
    idle(1);
    send(200); send(100);
    #1 rst = 1;
    #1;
    chk("t5 reset out_valid", int'(vld[0]), 0);
    chk("t5 reset out_max", int'(mxo[0]), 0);
    #1 rst = 0;
    @(posedge clk);
    #1;
    send(1); send(2); send(3); send(4);
    chk("t5 after reset max", int'(mxo[0]), 4);
    idle(1);
    out_ready = 0;
    send(50); send(60); send(70); send(80);
    chk("t5b done valid", int'(vld[0]), 1);
    #1 rst = 1;
    #1;
    chk("t5b async clear valid", int'(vld[0]), 0);
    chk("t5b async clear ready", int'(rdy[0]), 1);
    #1 rst = 0;
    out_ready = 1;
    @(posedge clk);
    #1;
    send(9); send(30); send(30); send(4);
    chk("t6 tie max", int'(mxo[0]), 30);
`ifdef MAX_SEQ_ARGMAX_EN
    chk("t6 tie idx", int'(idxo[0]), 1);
`endif
    idle(2);
    out_ready = 0;
    send(55);
    chk("t6 N1 valid", int'(vld[1]), 1);
    chk("t6 N1 max", int'(mxo[1]), 55);
`ifdef MAX_SEQ_ARGMAX_EN
    chk("t6 N1 idx", int'(idxo[1]), 0);
`endif
    chk("t6 N4 still ready", int'(rdy[0]), 1);
    out_ready = 1;
    idle(2);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
